// File: rtl/change_dispense_ctrl.sv
// Change dispenser sequencer: pays out an owed amount one coin at a time, largest
// denomination first, skipping empty tubes. Optional ack timeout under CHANGE_TIMEOUT_EN.
module change_dispense_ctrl #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_amount,
  input  logic       i_quarter_empty,
  input  logic       i_dime_empty,
  input  logic       i_nickle_empty,
  input  logic       i_coin_ack,
  output logic       o_coin_req,
  output logic [1:0] o_coin_type,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_remaining,
  output logic       o_error
);

  // state  | meaning
  // IDLE   | waiting for start
  // SELECT | pick next coin, or finish when nothing is owed
  // REQ    | coin_req held until the dispenser acks
  // DONE   | one-cycle done pulse
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_REQ    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] COIN_PENNY   = 2'b00;
  localparam logic [1:0] COIN_NICKLE  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  logic [1:0] r_state;
  logic       r_coin_req;
  logic [1:0] r_coin_type;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_remaining;

  logic [1:0] w_sel_type;
  logic [7:0] w_coin_val;

  // Penny is always available, so it is the fallback when nothing larger fits.
  always_comb begin
    w_sel_type = COIN_PENNY;
    if (!i_quarter_empty && (r_remaining >= 8'd25)) begin
      w_sel_type = COIN_QUARTER;
    end else if (!i_dime_empty && (r_remaining >= 8'd10)) begin
      w_sel_type = COIN_DIME;
    end else if (!i_nickle_empty && (r_remaining >= 8'd5)) begin
      w_sel_type = COIN_NICKLE;
    end
  end

  always_comb begin
    w_coin_val = 8'd1;
    case (r_coin_type)
      COIN_QUARTER: w_coin_val = 8'd25;
      COIN_DIME:    w_coin_val = 8'd10;
      COIN_NICKLE:  w_coin_val = 8'd5;
      default:      w_coin_val = 8'd1;
    endcase
  end

`ifdef CHANGE_TIMEOUT_EN
  logic [7:0] r_ack_cnt;
  logic       r_error;
  logic       w_timeout;

  assign w_timeout = (({1'b0, r_ack_cnt} + 9'd1) >= 9'(ACK_TIMEOUT));
  assign o_error   = r_error;
`else
  assign o_error   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_coin_req  <= 1'b0;
      r_coin_type <= COIN_PENNY;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= 8'd0;
`ifdef CHANGE_TIMEOUT_EN
      r_ack_cnt   <= 8'd0;
      r_error     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_remaining <= i_amount;
            r_busy      <= 1'b1;
            r_state     <= S_SELECT;
`ifdef CHANGE_TIMEOUT_EN
            r_error     <= 1'b0;
`endif
          end
        end
        S_SELECT: begin
          if (r_remaining == 8'd0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_coin_type <= w_sel_type;
            r_coin_req  <= 1'b1;
            r_state     <= S_REQ;
`ifdef CHANGE_TIMEOUT_EN
            r_ack_cnt   <= 8'd0;
`endif
          end
        end
        S_REQ: begin
          // Coin value never exceeds remaining, so this cannot wrap.
          if (i_coin_ack) begin
            r_remaining <= r_remaining - w_coin_val;
            r_coin_req  <= 1'b0;
            r_state     <= S_SELECT;
`ifdef CHANGE_TIMEOUT_EN
          end else if (w_timeout) begin
            r_error    <= 1'b1;
            r_coin_req <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_ack_cnt <= r_ack_cnt + 8'd1;
`endif
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_coin_req  = r_coin_req;
  assign o_coin_type = r_coin_type;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_remaining = r_remaining;

endmodule
